// File: rtl/score_pkg.sv
// Shared field layout, note-range constants and FSM state type for the score sequencer.
package score_pkg;

   localparam int unsigned NOTE_MSB = 11;
   localparam int unsigned NOTE_LSB = 8;
   localparam int unsigned OCT_MSB  = 7;
   localparam int unsigned OCT_LSB  = 5;
   localparam int unsigned DUR_MSB  = 4;
   localparam int unsigned DUR_LSB  = 0;
   localparam int unsigned DUR_W    = DUR_MSB - DUR_LSB + 1;

   localparam logic [3:0] NOTE_REST = 4'd0;
   localparam logic [3:0] NOTE_MAX  = 4'd13;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_PLAY  = 2'd2,
      ST_PAUSE = 2'd3
   } state_e;

   // Codes above NOTE_MAX are treated as rests, same as NOTE_REST.
   function automatic logic is_tone(input logic [3:0] note);
      return (note != NOTE_REST) && (note <= NOTE_MAX);
   endfunction

endpackage

// File: rtl/score_sequencer_dur_counter.sv
// Per-entry beat counter: loaded with the entry duration, counts ticks down, holds while paused.
module dur_counter
   import score_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_i,
   input  logic             load_i,
   input  logic [DUR_W-1:0] load_val_i,
   input  logic             tick_i,
   input  logic             hold_i,
   output logic             last_o
);

   logic [DUR_W-1:0] remain_q, remain_d;

   // Stops at 1: the owner advances on the final tick and reloads, so no underflow.
   always_comb begin
      remain_d = remain_q;
      if (clear_i) begin
         remain_d = '0;
      end else if (load_i) begin
         remain_d = load_val_i;
      end else if (tick_i && !hold_i && (remain_q > DUR_W'(1))) begin
         remain_d = remain_q - DUR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remain_q <= '0;
      end else begin
         remain_q <= remain_d;
      end
   end

   assign last_o = (remain_q == DUR_W'(1));

endmodule

// File: rtl/score_sequencer.sv
// Score playback sequencer: walks the score memory, holds each entry for its beat count,
// and drives note/octave to the tone generator with play/pause/stop/loop control.
module score_sequencer
   import score_pkg::*;
#(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned SONG_LEN = 150,
   parameter bit          ARTIC    = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tick,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   input  logic              loop_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [11:0]       rd_data,
   output logic [3:0]        note_out,
   output logic [2:0]        octave_out,
   output logic              note_valid,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] pos_out
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SONG_LEN - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [3:0]        note_q, note_d;
   logic [2:0]        oct_q, oct_d;
   logic [DUR_W-1:0]  dur_q, dur_d;
   logic              done_q, done_d;

   logic              cnt_clear, cnt_load, cnt_last, advance;
   logic [DUR_W-1:0]  fetch_dur;

   assign fetch_dur = rd_data[DUR_MSB:DUR_LSB];

   dur_counter u_dur_counter (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_i    (cnt_clear),
      .load_i     (cnt_load),
      .load_val_i (fetch_dur),
      .tick_i     (tick && (state_q == ST_PLAY)),
      .hold_i     (pause),
      .last_o     (cnt_last)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      note_d    = note_q;
      oct_d     = oct_q;
      dur_d     = dur_q;
      done_d    = 1'b0;
      cnt_clear = 1'b0;
      cnt_load  = 1'b0;
      advance   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            note_d = rd_data[NOTE_MSB:NOTE_LSB];
            oct_d  = rd_data[OCT_MSB:OCT_LSB];
            dur_d  = fetch_dur;
            if (fetch_dur == '0) begin
               advance = 1'b1;
            end else begin
               cnt_load = 1'b1;
               state_d  = ST_PLAY;
            end
         end
         ST_PLAY: begin
            if (pause)                 state_d = ST_PAUSE;
            else if (tick && cnt_last) advance = 1'b1;
         end
         ST_PAUSE: begin
            if (!pause) state_d = ST_PLAY;
         end
         default: state_d = ST_IDLE;
      endcase

      if (advance) begin
         if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (loop_en) begin
               state_d = ST_FETCH;
            end else begin
               state_d   = ST_IDLE;
               done_d    = 1'b1;
               note_d    = '0;
               oct_d     = '0;
               dur_d     = '0;
               cnt_clear = 1'b1;
            end
         end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = ST_FETCH;
         end
      end

      // Applied last so it overrides start, advance and done from every state.
      if (stop) begin
         state_d   = ST_IDLE;
         idx_d     = '0;
         note_d    = '0;
         oct_d     = '0;
         dur_d     = '0;
         done_d    = 1'b0;
         cnt_clear = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         note_q  <= '0;
         oct_q   <= '0;
         dur_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         note_q  <= note_d;
         oct_q   <= oct_d;
         dur_q   <= dur_d;
         done_q  <= done_d;
      end
   end

   assign rd_addr    = idx_q;
   assign pos_out    = idx_q;
   assign note_out   = note_q;
   assign octave_out = oct_q;
   assign busy       = (state_q != ST_IDLE);
   assign done       = done_q;
   assign note_valid = (state_q == ST_PLAY) && is_tone(note_q)
                       && !(ARTIC && (dur_q >= DUR_W'(2)) && cnt_last);

endmodule

// File: tb/tb_score_sequencer.sv
// Directed bench for score_sequencer with a 4-entry score; second instance built legato.
module tb_score_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tick = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0, loop_en = 1'b0;
   logic [15:0] rd_addr, pos_out;
   logic [11:0] rd_data;
   logic [3:0]  note_out;
   logic [2:0]  octave_out;
   logic        note_valid, busy, done;

   logic        start2 = 1'b0, stop2 = 1'b0;
   logic [15:0] rd_addr2, pos_out2;
   logic [11:0] rd_data2;
   logic [3:0]  note_out2;
   logic [2:0]  octave_out2;
   logic        note_valid2, busy2, done2;

   logic [11:0] mem [0:3];
   int unsigned total = 0, passed = 0;

   always #5 clk = ~clk;

   assign rd_data  = (rd_addr < 16'd4) ? mem[rd_addr[1:0]] : 12'h000;
   assign rd_data2 = (rd_addr2 < 16'd4) ? 12'h624 : 12'h000;

   score_sequencer #(.ADDR_W(16), .SONG_LEN(4), .ARTIC(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .stop(stop), .pause(pause),
      .loop_en(loop_en), .rd_addr(rd_addr), .rd_data(rd_data), .note_out(note_out),
      .octave_out(octave_out), .note_valid(note_valid), .busy(busy), .done(done),
      .pos_out(pos_out)
   );

   score_sequencer #(.ADDR_W(16), .SONG_LEN(4), .ARTIC(1'b0)) dut_legato (
      .clk(clk), .rst_n(rst_n), .tick(tick), .start(start2), .stop(stop2), .pause(1'b0),
      .loop_en(1'b0), .rd_addr(rd_addr2), .rd_data(rd_data2), .note_out(note_out2),
      .octave_out(octave_out2), .note_valid(note_valid2), .busy(busy2), .done(done2),
      .pos_out(pos_out2)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cyc(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic tick_now();
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
   endtask

   // n ticks spaced 4 clk apart, ending 1 clk after the last tick edge
   task automatic ticks(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         if (i != 0) cyc(3);
         tick_now();
      end
   endtask

   initial begin
      mem[0] = 12'h624; mem[1] = 12'h926; mem[2] = 12'h000; mem[3] = 12'h221;
      cyc(2);
      chk("rst_busy", 16'(busy), 16'd0);
      chk("rst_note", 16'(note_out), 16'd0);
      chk("rst_valid", 16'(note_valid), 16'd0);
      chk("rst_addr", rd_addr, 16'd0);
      rst_n = 1'b1;
      cyc(1);

      // 1: full song, no loop
      start = 1'b1; cyc(1); start = 1'b0;
      chk("t1_fetch_busy", 16'(busy), 16'd1);
      chk("t1_fetch_valid", 16'(note_valid), 16'd0);
      cyc(1);
      chk("t1_e0_note", 16'(note_out), 16'd6);
      chk("t1_e0_oct", 16'(octave_out), 16'd1);
      chk("t1_e0_valid", 16'(note_valid), 16'd1);
      ticks(3); cyc(1);
      chk("t1_e0_artic", 16'(note_valid), 16'd0);
      chk("t1_e0_hold", 16'(note_out), 16'd6);
      cyc(2); tick_now();
      chk("t1_e1_fetch_pos", pos_out, 16'd1);
      chk("t1_e1_fetch_valid", 16'(note_valid), 16'd0);
      cyc(1);
      chk("t1_e1_note", 16'(note_out), 16'd9);
      chk("t1_e1_valid", 16'(note_valid), 16'd1);
      cyc(2); ticks(5);
      chk("t1_e1_artic", 16'(note_valid), 16'd0);
      cyc(3); tick_now();
      chk("t1_e2_pos", pos_out, 16'd2);
      cyc(1);
      chk("t1_skip_pos", pos_out, 16'd3);
      chk("t1_skip_busy", 16'(busy), 16'd1);
      cyc(1);
      chk("t1_e3_note", 16'(note_out), 16'd2);
      chk("t1_e3_oct", 16'(octave_out), 16'd1);
      chk("t1_e3_valid", 16'(note_valid), 16'd1);
      cyc(2); tick_now();
      chk("t1_done", 16'(done), 16'd1);
      chk("t1_idle_busy", 16'(busy), 16'd0);
      chk("t1_idle_note", 16'(note_out), 16'd0);
      chk("t1_idle_pos", pos_out, 16'd0);
      cyc(1);
      chk("t1_done_pulse", 16'(done), 16'd0);

      // 2: loop
      loop_en = 1'b1;
      start = 1'b1; cyc(1); start = 1'b0; cyc(1);
      cyc(2); ticks(4); cyc(1);
      cyc(2); ticks(6); cyc(2);
      chk("t2_e3_note", 16'(note_out), 16'd2);
      cyc(2); tick_now();
      chk("t2_wrap_pos", pos_out, 16'd0);
      chk("t2_no_done", 16'(done), 16'd0);
      chk("t2_wrap_busy", 16'(busy), 16'd1);
      cyc(1);
      chk("t2_replay_note", 16'(note_out), 16'd6);
      chk("t2_replay_valid", 16'(note_valid), 16'd1);

      // 3: pause with remain=3
      cyc(2); tick_now();
      pause = 1'b1; cyc(1);
      chk("t3_pause_valid", 16'(note_valid), 16'd0);
      chk("t3_pause_note", 16'(note_out), 16'd6);
      for (int unsigned i = 0; i < 5; i++) begin
         cyc(3); tick_now();
      end
      chk("t3_pause_pos", pos_out, 16'd0);
      pause = 1'b0; cyc(1);
      chk("t3_resume_valid", 16'(note_valid), 16'd1);
      cyc(2); ticks(2); cyc(1);
      chk("t3_last_artic", 16'(note_valid), 16'd0);
      chk("t3_still_e0", pos_out, 16'd0);
      cyc(2); tick_now();
      chk("t3_to_e1", pos_out, 16'd1);
      cyc(1);
      chk("t3_e1_note", 16'(note_out), 16'd9);

      // 4: stop, then stop+start together
      stop = 1'b1; cyc(1); stop = 1'b0;
      chk("t4_busy", 16'(busy), 16'd0);
      chk("t4_note", 16'(note_out), 16'd0);
      chk("t4_addr", rd_addr, 16'd0);
      chk("t4_valid", 16'(note_valid), 16'd0);
      start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
      chk("t4_stop_wins", 16'(busy), 16'd0);
      cyc(1);
      chk("t4_still_idle", 16'(busy), 16'd0);

      // 5: start ignored while busy; async reset
      loop_en = 1'b0;
      start = 1'b1; cyc(1); start = 1'b0; cyc(1);
      cyc(2); tick_now();
      start = 1'b1; cyc(1); start = 1'b0;
      chk("t5_restart_pos", pos_out, 16'd0);
      chk("t5_restart_valid", 16'(note_valid), 16'd1);
      cyc(1); ticks(3);
      chk("t5_e1_pos", pos_out, 16'd1);
      cyc(1);
      start = 1'b1; cyc(1); start = 1'b0;
      chk("t5_e1_keep_pos", pos_out, 16'd1);
      chk("t5_e1_keep_note", 16'(note_out), 16'd9);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_busy", 16'(busy), 16'd0);
      chk("t5_rst_note", 16'(note_out), 16'd0);
      chk("t5_rst_valid", 16'(note_valid), 16'd0);
      chk("t5_rst_pos", pos_out, 16'd0);
      cyc(1);
      rst_n = 1'b1;
      cyc(1);

      // 6: rest entry 0x044
      mem[0] = 12'h044;
      start = 1'b1; cyc(1); start = 1'b0; cyc(1);
      chk("t6_rest_busy", 16'(busy), 16'd1);
      chk("t6_rest_note", 16'(note_out), 16'd0);
      chk("t6_rest_oct", 16'(octave_out), 16'd2);
      for (int unsigned i = 0; i < 3; i++) begin
         cyc(2); tick_now();
         chk("t6_rest_valid", 16'(note_valid), 16'd0);
      end
      cyc(2); tick_now();
      chk("t6_rest_adv", pos_out, 16'd1);
      stop = 1'b1; cyc(1); stop = 1'b0;

      // ARTIC=0 instance: valid on all four ticks of 0x624
      start2 = 1'b1; cyc(1); start2 = 1'b0; cyc(1);
      chk("t6_leg_note", 16'(note_out2), 16'd6);
      chk("t6_leg_valid0", 16'(note_valid2), 16'd1);
      cyc(2); ticks(3); cyc(1);
      chk("t6_leg_last_valid", 16'(note_valid2), 16'd1);
      chk("t6_leg_pos", pos_out2, 16'd0);
      cyc(2); tick_now();
      chk("t6_leg_adv", pos_out2, 16'd1);
      stop2 = 1'b1; cyc(1); stop2 = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish, required finish");
      $fatal(1, "timeout");
   end

endmodule
